// File: rtl/bench_bist_ctrl.sv
// bench_bist_ctrl - BIST controller for a 50-in / 22-out combinational core.
//
// Drives the core's input side from a maximal-length LFSR and compacts the
// core's responses into a MISR. After N_PATTERNS patterns it spends one CHECK
// cycle and then parks in DONE, where the final signature is held.
//
// Optional feature macro: BIST_GOLDEN_CMP_EN
//   defined   - signature is compared to GOLDEN_SIG in CHECK and registered
//               into pass.
//   undefined - no comparator is built and pass is tied to 0. The CHECK
//               cycle is still spent, so timing does not change.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous reset, active high
//   start      in   begin a run (honoured in IDLE and DONE only)
//   pat_out    out  [IN_W-1:0]  stimulus to the core (the LFSR register)
//   pat_valid  out  pat_out carries a pattern that will be compacted
//   resp_in    in   [OUT_W-1:0] core response, combinational from pat_out
//   busy       out  high in RUN and CHECK
//   done       out  high in DONE
//   pass       out  signature matched GOLDEN_SIG (valid when done=1)
//   signature  out  [OUT_W-1:0] current MISR contents
//   pat_count  out  [15:0] patterns applied in the current run
module bench_bist_ctrl #(
    parameter int                IN_W       = 50,
    parameter int                OUT_W      = 22,
    parameter int                N_PATTERNS = 1024,
    parameter logic [IN_W-1:0]   SEED       = {{(IN_W-1){1'b0}}, 1'b1},
    parameter logic [OUT_W-1:0]  GOLDEN_SIG = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [IN_W-1:0]  pat_out,
    output logic             pat_valid,
    input  logic [OUT_W-1:0] resp_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [OUT_W-1:0] signature,
    output logic [15:0]      pat_count
);

    // An all-zero seed would lock the LFSR up, so it is replaced by 1.
    localparam logic [IN_W-1:0] SEED_ONE = {{(IN_W-1){1'b0}}, 1'b1};
    localparam logic [IN_W-1:0] SEED_EFF = (SEED == '0) ? SEED_ONE : SEED;
    localparam logic [15:0]     CNT_LAST = 16'(N_PATTERNS - 1);
    localparam logic [15:0]     CNT_MAX  = 16'(N_PATTERNS);

    typedef enum logic [1:0] {IDLE, RUN, CHECK, DONE} state_t;

    state_t           state, state_nxt;
    logic [IN_W-1:0]  lfsr, lfsr_nxt;
    logic [OUT_W-1:0] misr, misr_nxt;
    logic [15:0]      cnt;
    logic             load;

    // start reloads the datapath only where it is honoured.
    assign load = start && (state == IDLE || state == DONE);

    // Fibonacci LFSR, taps 50/49/24/23.
    assign lfsr_nxt = {lfsr[IN_W-2:0], lfsr[49] ^ lfsr[48] ^ lfsr[23] ^ lfsr[22]};
    // MISR, taps 22/21, response folded in after the shift.
    assign misr_nxt = {misr[OUT_W-2:0], misr[21] ^ misr[20]} ^ resp_in;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (cnt == CNT_LAST) state_nxt = CHECK;
            CHECK:   state_nxt = DONE;
            DONE:    if (start) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        pat_valid = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            RUN:     begin pat_valid = 1'b1; busy = 1'b1; end
            CHECK:   busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk) begin
        if (rst || load) begin
            lfsr <= SEED_EFF;
            misr <= '0;
            cnt  <= '0;
        end else if (state == RUN) begin
            lfsr <= lfsr_nxt;
            misr <= misr_nxt;
            if (cnt != CNT_MAX) cnt <= cnt + 16'd1;
        end
    end

`ifdef BIST_GOLDEN_CMP_EN
    logic pass_q;
    // Signature is final once RUN ends, so the compare is taken in CHECK.
    always_ff @(posedge clk) begin
        if (rst || load)         pass_q <= 1'b0;
        else if (state == CHECK) pass_q <= (misr == GOLDEN_SIG);
    end
    assign pass = pass_q;
`else
    // Comparator not built; GOLDEN_SIG is kept only for a uniform interface.
    logic unused_golden;
    assign unused_golden = ^GOLDEN_SIG;
    assign pass          = 1'b0;
`endif

    assign pat_out   = lfsr;
    assign signature = misr;
    assign pat_count = cnt;

endmodule
